// File: rtl/vec_pkg.sv
// Shared definitions for the vector issue controller: field positions, lane modes,
// FSM states and the decoded-instruction payload.
package vec_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned DS_W   = 64;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned OP_W   = 5;
  localparam int unsigned VM_W   = 3;

  localparam int unsigned F_ALU_OP_LSB = 27;
  localparam int unsigned F_V_MODE_LSB = 24;
  localparam int unsigned F_IMM        = 23;
  localparam int unsigned F_MANDA      = 22;
  localparam int unsigned F_W_ADDR_LSB = 17;
  localparam int unsigned F_R_ADDR_LSB = 12;
  localparam int unsigned F_S_ADDR_LSB = 7;
  localparam int unsigned F_RSVD_W     = 7;

  typedef enum logic [VM_W-1:0] {
    VM_NIB     = 3'b000,
    VM_BYTE    = 3'b001,
    VM_WORD    = 3'b010,
    VM_DWORD   = 3'b011,
    VM_QUAD    = 3'b100,
    VM_MANDA4  = 3'b101,
    VM_MANDA8  = 3'b110,
    VM_MANDA16 = 3'b111
  } v_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_IMM_HI = 3'd1,
    ST_IMM_LO = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MANDA1 = 3'd4,
    ST_MANDA2 = 3'd5
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0]   alu_op;
    v_mode_e           v_mode;
    logic              imm;
    logic              manda;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] s_addr;
  } inst_fields_t;

  function automatic logic is_manda_mode(input v_mode_e m);
    return (m == VM_MANDA4) || (m == VM_MANDA8) || (m == VM_MANDA16);
  endfunction

endpackage

// File: rtl/vector_issue_ctrl_if.sv
// Instruction handshake plus datapath control bundle between the issue controller
// (slave side) and its instruction source / VectorDP (master side).
interface vector_issue_ctrl_if;
  import vec_pkg::*;

  logic              Inst_Valid;
  logic [INST_W-1:0] Inst;
  logic              Inst_Ready;
  logic              W_En;
  logic [ADDR_W-1:0] W_Addr;
  logic [ADDR_W-1:0] R_Addr;
  logic [ADDR_W-1:0] S_Addr;
  logic [OP_W-1:0]   ALU_Op;
  logic [VM_W-1:0]   V_Mode;
  logic              S_Sel;
  logic              MANDA_En;
  logic [DS_W-1:0]   DS;
  logic              Busy;
  logic              Done;
  logic              Err;

  modport master (
    output Inst_Valid, Inst,
    input  Inst_Ready, W_En, W_Addr, R_Addr, S_Addr, ALU_Op, V_Mode,
           S_Sel, MANDA_En, DS, Busy, Done, Err
  );

  modport slave (
    input  Inst_Valid, Inst,
    output Inst_Ready, W_En, W_Addr, R_Addr, S_Addr, ALU_Op, V_Mode,
           S_Sel, MANDA_En, DS, Busy, Done, Err
  );
endinterface

// File: rtl/vec_inst_decode.sv
// Combinational field extraction and legality check for one instruction word.
module vec_inst_decode
  import vec_pkg::*;
(
  input  logic [INST_W-1:0] inst,
  output inst_fields_t      fields_c,
  output logic              legal_c
);

  always_comb begin
    fields_c        = '0;
    fields_c.alu_op = inst[F_ALU_OP_LSB +: OP_W];
    fields_c.v_mode = v_mode_e'(inst[F_V_MODE_LSB +: VM_W]);
    fields_c.imm    = inst[F_IMM];
    fields_c.manda  = inst[F_MANDA];
    fields_c.w_addr = inst[F_W_ADDR_LSB +: ADDR_W];
    fields_c.r_addr = inst[F_R_ADDR_LSB +: ADDR_W];
    fields_c.s_addr = inst[F_S_ADDR_LSB +: ADDR_W];
    // MANDA flag must agree with the lane mode and the reserved tail must be clear
    legal_c = (fields_c.manda == is_manda_mode(fields_c.v_mode)) &&
              (inst[F_RSVD_W-1:0] == F_RSVD_W'(0));
  end

endmodule

// File: rtl/vector_issue_ctrl.sv
// Issue stage for VectorDP: instruction/immediate collection and MANDA sequencing.
// Optional statistics counters are enabled with VEC_ISSUE_STATS_EN.
module vector_issue_ctrl
  import vec_pkg::*;
(
  input  logic                W_Clk,
  input  logic                Rst_n,
  vector_issue_ctrl_if.slave  bus
`ifdef VEC_ISSUE_STATS_EN
  ,
  output logic [CNT_W-1:0]    Stat_Issued,
  output logic [CNT_W-1:0]    Stat_Stall
`endif
);

  state_e          state_q, state_d;
  inst_fields_t    op_q, op_d;
  logic [DS_W-1:0] ds_q, ds_d;
  logic            ready_q, ready_d;
  logic            w_en_q, w_en_d;
  logic            manda_en_q, manda_en_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;

  inst_fields_t    dec_c;
  logic            legal_c;
  logic            accept_c;

  vec_inst_decode u_decode (
    .inst     (bus.Inst),
    .fields_c (dec_c),
    .legal_c  (legal_c)
  );

  assign accept_c = bus.Inst_Valid & ready_q;

  // Next state, latched fields and the registered control outputs they imply
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ds_d    = ds_q;
    err_d   = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_EXEC, ST_MANDA2: begin
        state_d = ST_IDLE;
        if (accept_c) begin
          if (legal_c) begin
            op_d    = dec_c;
            state_d = dec_c.imm ? ST_IMM_HI : (dec_c.manda ? ST_MANDA1 : ST_EXEC);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_IMM_HI: begin
        if (accept_c) begin
          ds_d[DS_W-1 -: INST_W] = bus.Inst;
          state_d                = ST_IMM_LO;
        end
      end
      ST_IMM_LO: begin
        if (accept_c) begin
          ds_d[INST_W-1:0] = bus.Inst;
          state_d          = op_q.manda ? ST_MANDA1 : ST_EXEC;
        end
      end
      ST_MANDA1: state_d = ST_MANDA2;
      default:   state_d = ST_IDLE;
    endcase

    ready_d    = (state_d != ST_MANDA1);
    w_en_d     = (state_d == ST_EXEC) || (state_d == ST_MANDA2);
    done_d     = w_en_d;
    manda_en_d = (state_d == ST_MANDA1);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge W_Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      ds_q       <= '0;
      ready_q    <= 1'b0;
      w_en_q     <= 1'b0;
      manda_en_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      ds_q       <= ds_d;
      ready_q    <= ready_d;
      w_en_q     <= w_en_d;
      manda_en_q <= manda_en_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.Inst_Ready = ready_q;
  assign bus.W_En       = w_en_q;
  assign bus.MANDA_En   = manda_en_q;
  assign bus.Done       = done_q;
  assign bus.Err        = err_q;
  assign bus.Busy       = busy_q;
  assign bus.W_Addr     = op_q.w_addr;
  assign bus.R_Addr     = op_q.r_addr;
  assign bus.S_Addr     = op_q.s_addr;
  assign bus.ALU_Op     = op_q.alu_op;
  assign bus.V_Mode     = op_q.v_mode;
  assign bus.S_Sel      = op_q.imm;
  assign bus.DS         = ds_q;

`ifdef VEC_ISSUE_STATS_EN
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  // Issued counts Done pulses; stall counts offered-but-refused cycles
  always_comb begin
    issued_d = issued_q + CNT_W'(done_q);
    stall_d  = stall_q + CNT_W'(bus.Inst_Valid & ~ready_q);
  end

  always_ff @(posedge W_Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      issued_q <= issued_d;
      stall_q  <= stall_d;
    end
  end

  assign Stat_Issued = issued_q;
  assign Stat_Stall  = stall_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_vector_issue_ctrl.sv
// Self-checking bench for vector_issue_ctrl: directed scenarios plus a randomized
// instruction stream checked against a transaction-level expectation model.
module tb_vector_issue_ctrl;
  import vec_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vector_issue_ctrl_if bus ();

  vector_issue_ctrl dut (
    .W_Clk (clk),
    .Rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] ds_model = 64'h0;

  // Control bits in order {W_En, MANDA_En, Done, Err, Inst_Ready, Busy}
  localparam logic [5:0] C_RESET = 6'b000000;
  localparam logic [5:0] C_IDLE  = 6'b000010;
  localparam logic [5:0] C_IMM   = 6'b000011;
  localparam logic [5:0] C_WRITE = 6'b101011;
  localparam logic [5:0] C_MANDA = 6'b010001;
  localparam logic [5:0] C_ERR   = 6'b000110;

  function automatic logic [5:0] ctl();
    return {bus.W_En, bus.MANDA_En, bus.Done, bus.Err, bus.Inst_Ready, bus.Busy};
  endfunction

  function automatic logic [23:0] flds();
    return {bus.W_Addr, bus.R_Addr, bus.S_Addr, bus.ALU_Op, bus.V_Mode, bus.S_Sel};
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [2:0] vm,
                                     input logic imm, input logic manda,
                                     input logic [4:0] w, input logic [4:0] r,
                                     input logic [4:0] s, input logic [6:0] rsvd);
    return {op, vm, imm, manda, w, r, s, rsvd};
  endfunction

  // Drive one word on the falling edge, let one rising edge pass, sample 1ns later
  task automatic step(input logic v, input logic [31:0] w);
    @(negedge clk);
    bus.Inst_Valid = v;
    bus.Inst       = w;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if (ctl() !== C_RESET) begin n_fail++; $display("FAIL reset_ctl: got %b expected %b", ctl(), C_RESET); end
    n_checks++;
    if (flds() !== 24'h0 || bus.DS !== 64'h0) begin
      n_fail++; $display("FAIL reset_fields: got %h/%h expected 0/0", flds(), bus.DS);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (ctl() !== C_IDLE) begin n_fail++; $display("FAIL reset_release: got %b expected %b", ctl(), C_IDLE); end
  endtask

  task automatic test_add();
    step(1'b1, mk(5'd1, 3'b001, 1'b0, 1'b0, 5'd3, 5'd1, 5'd2, 7'd0));
    n_checks++;
    if (ctl() !== C_WRITE) begin n_fail++; $display("FAIL add_ctl: got %b expected %b", ctl(), C_WRITE); end
    n_checks++;
    if (flds() !== {5'd3, 5'd1, 5'd2, 5'd1, 3'b001, 1'b0}) begin
      n_fail++; $display("FAIL add_fields: got %h expected %h", flds(), {5'd3, 5'd1, 5'd2, 5'd1, 3'b001, 1'b0});
    end
    step(1'b0, 32'h0);
    n_checks++;
    if (ctl() !== C_IDLE) begin n_fail++; $display("FAIL add_idle: got %b expected %b", ctl(), C_IDLE); end
  endtask

  task automatic test_immediate();
    step(1'b1, mk(5'd5, 3'b010, 1'b1, 1'b0, 5'd7, 5'd4, 5'd9, 7'd0));
    n_checks++;
    if (ctl() !== C_IMM) begin n_fail++; $display("FAIL imm_hi: got %b expected %b", ctl(), C_IMM); end
    step(1'b1, 32'hDEADBEEF);
    n_checks++;
    if (ctl() !== C_IMM) begin n_fail++; $display("FAIL imm_lo: got %b expected %b", ctl(), C_IMM); end
    step(1'b1, 32'h01234567);
    ds_model = 64'hDEADBEEF01234567;
    n_checks++;
    if (ctl() !== C_WRITE) begin n_fail++; $display("FAIL imm_write: got %b expected %b", ctl(), C_WRITE); end
    n_checks++;
    if (bus.DS !== ds_model || bus.S_Sel !== 1'b1) begin
      n_fail++; $display("FAIL imm_ds: got %h sel %b expected %h sel 1", bus.DS, bus.S_Sel, ds_model);
    end
    step(1'b0, 32'h0);
    n_checks++;
    if (ctl() !== C_IDLE || bus.DS !== ds_model) begin
      n_fail++; $display("FAIL imm_hold: got %b %h expected %b %h", ctl(), bus.DS, C_IDLE, ds_model);
    end
  endtask

  task automatic test_manda();
    step(1'b1, mk(5'd9, 3'b110, 1'b0, 1'b1, 5'd12, 5'd13, 5'd14, 7'd0));
    n_checks++;
    if (ctl() !== C_MANDA) begin n_fail++; $display("FAIL manda1: got %b expected %b", ctl(), C_MANDA); end
    // Offer a word while not ready: it must be ignored
    step(1'b1, mk(5'd2, 3'b000, 1'b0, 1'b0, 5'd1, 5'd1, 5'd1, 7'd0));
    n_checks++;
    if (ctl() !== C_WRITE) begin n_fail++; $display("FAIL manda2: got %b expected %b", ctl(), C_WRITE); end
    n_checks++;
    if (flds() !== {5'd12, 5'd13, 5'd14, 5'd9, 3'b110, 1'b0}) begin
      n_fail++; $display("FAIL manda_fields: got %h expected %h", flds(), {5'd12, 5'd13, 5'd14, 5'd9, 3'b110, 1'b0});
    end
    step(1'b0, 32'h0);
    n_checks++;
    if (ctl() !== C_IDLE) begin n_fail++; $display("FAIL manda_idle: got %b expected %b", ctl(), C_IDLE); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, mk(5'(i + 3), 3'b011, 1'b0, 1'b0, 5'(20 + i), 5'(i), 5'(i + 1), 7'd0));
      n_checks++;
      if (ctl() !== C_WRITE || bus.W_Addr !== 5'(20 + i)) begin
        n_fail++; $display("FAIL b2b_%0d: got %b w%0d expected %b w%0d", i, ctl(), bus.W_Addr, C_WRITE, 20 + i);
      end
    end
    step(1'b0, 32'h0);
    n_checks++;
    if (ctl() !== C_IDLE) begin n_fail++; $display("FAIL b2b_idle: got %b expected %b", ctl(), C_IDLE); end
  endtask

  task automatic test_illegal();
    step(1'b1, mk(5'd4, 3'b101, 1'b0, 1'b0, 5'd6, 5'd6, 5'd6, 7'd0));
    n_checks++;
    if (ctl() !== C_ERR) begin n_fail++; $display("FAIL illegal_err: got %b expected %b", ctl(), C_ERR); end
    step(1'b1, mk(5'd8, 3'b100, 1'b0, 1'b0, 5'd30, 5'd29, 5'd28, 7'd0));
    n_checks++;
    if (ctl() !== C_WRITE || flds() !== {5'd30, 5'd29, 5'd28, 5'd8, 3'b100, 1'b0}) begin
      n_fail++; $display("FAIL illegal_next: got %b %h expected %b %h", ctl(), flds(), C_WRITE,
                         {5'd30, 5'd29, 5'd28, 5'd8, 3'b100, 1'b0});
    end
    step(1'b0, 32'h0);
  endtask

  task automatic test_reset_mid_manda();
    step(1'b1, mk(5'd11, 3'b111, 1'b0, 1'b1, 5'd15, 5'd16, 5'd17, 7'd0));
    n_checks++;
    if (ctl() !== C_MANDA) begin n_fail++; $display("FAIL rst_manda1: got %b expected %b", ctl(), C_MANDA); end
    #2 rst_n = 1'b0;
    #1;
    ds_model = 64'h0;
    n_checks++;
    if (ctl() !== C_RESET || flds() !== 24'h0 || bus.DS !== 64'h0) begin
      n_fail++; $display("FAIL rst_async: got %b %h %h expected all zero", ctl(), flds(), bus.DS);
    end
    @(negedge clk);
    bus.Inst_Valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 32'h0);
      n_checks++;
      if (ctl() !== C_IDLE) begin n_fail++; $display("FAIL rst_after_%0d: got %b expected %b", i, ctl(), C_IDLE); end
    end
    step(1'b1, mk(5'd1, 3'b001, 1'b0, 1'b0, 5'd3, 5'd1, 5'd2, 7'd0));
    n_checks++;
    if (ctl() !== C_WRITE || flds() !== {5'd3, 5'd1, 5'd2, 5'd1, 3'b001, 1'b0}) begin
      n_fail++; $display("FAIL rst_next_op: got %b %h expected %b %h", ctl(), flds(), C_WRITE,
                         {5'd3, 5'd1, 5'd2, 5'd1, 3'b001, 1'b0});
    end
  endtask

  // Random stream: each instruction runs to completion, optionally with idle gaps
  // before it and between its extension words.
  task automatic test_random();
    logic        illegal, imm, manda;
    logic [2:0]  vm;
    logic [4:0]  op, w, r, s;
    logic [6:0]  rsvd;
    logic [31:0] word, hi, lo;
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) begin
          step(1'b0, $urandom);
          n_checks++;
          if (ctl() !== C_IDLE) begin n_fail++; $display("FAIL rnd_gap %0d: got %b expected %b", n, ctl(), C_IDLE); end
        end
      end
      illegal = ($urandom_range(0, 5) == 0);
      imm     = 1'($urandom_range(0, 1));
      manda   = 1'($urandom_range(0, 1));
      op = 5'($urandom); w = 5'($urandom); r = 5'($urandom); s = 5'($urandom);
      vm   = manda ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      rsvd = 7'd0;
      if (illegal) begin
        if ($urandom_range(0, 1) == 0) vm = manda ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
        else rsvd = 7'($urandom_range(1, 127));
      end
      step(1'b1, mk(op, vm, imm, manda, w, r, s, rsvd));
      if (illegal) begin
        n_checks++;
        if (ctl() !== C_ERR) begin n_fail++; $display("FAIL rnd_err %0d: got %b expected %b", n, ctl(), C_ERR); end
        continue;
      end
      if (imm) begin
        hi = 32'h0;
        lo = 32'h0;
        for (int k = 0; k < 2; k++) begin
          n_checks++;
          if (ctl() !== C_IMM) begin n_fail++; $display("FAIL rnd_imm %0d.%0d: got %b expected %b", n, k, ctl(), C_IMM); end
          repeat ($urandom_range(0, 1)) begin
            step(1'b0, $urandom);
            n_checks++;
            if (ctl() !== C_IMM) begin n_fail++; $display("FAIL rnd_imm_wait %0d: got %b expected %b", n, ctl(), C_IMM); end
          end
          word = $urandom;
          step(1'b1, word);
          if (k == 0) hi = word;
          else lo = word;
        end
        ds_model = {hi, lo};
      end
      if (manda) begin
        n_checks++;
        if (ctl() !== C_MANDA) begin n_fail++; $display("FAIL rnd_manda1 %0d: got %b expected %b", n, ctl(), C_MANDA); end
        step(1'($urandom_range(0, 1)), $urandom);
      end
      n_checks++;
      if (ctl() !== C_WRITE) begin n_fail++; $display("FAIL rnd_write %0d: got %b expected %b", n, ctl(), C_WRITE); end
      n_checks++;
      if (flds() !== {w, r, s, op, vm, imm} || bus.DS !== ds_model) begin
        n_fail++; $display("FAIL rnd_fields %0d: got %h %h expected %h %h", n, flds(), bus.DS,
                           {w, r, s, op, vm, imm}, ds_model);
      end
    end
    step(1'b0, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Inst_Valid = 1'b0;
    bus.Inst       = 32'h0;
    test_reset();
    test_add();
    test_immediate();
    test_manda();
    test_back_to_back();
    test_illegal();
    test_reset_mid_manda();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
